// File: rtl/exe_stage.sv
// exe_stage: execute pipeline stage with a one-hot ALU and an iterative
// 32-cycle restoring divider (DIV.W / MOD.W / DIV.WU / MOD.WU).
// Optional build macro EXE_DIV_EARLY_OUT_EN: divides whose result is known
// up front (divisor zero, or |divisor| > |dividend|) skip the iterations.
module exe_stage #(
    parameter int unsigned SIDE_WD = 45
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_to_exe_valid,
    output logic               exe_allow_in,
    input  logic [31:0]        id_src1,
    input  logic [31:0]        id_src2,
    input  logic [18:0]        id_alu_op,
    input  logic [2:0]         id_div_op,
    input  logic               id_rf_w_en,
    input  logic [4:0]         id_rf_w_addr,
    input  logic               id_is_load,
    input  logic [SIDE_WD-1:0] id_side,
    input  logic [31:0]        id_pc,
    input  logic               mem_allow_in,
    output logic               exe_to_mem_valid,
    output logic [31:0]        exe_result,
    output logic               exe_rf_w_en,
    output logic [4:0]         exe_rf_w_addr,
    output logic [SIDE_WD-1:0] exe_side,
    output logic [31:0]        exe_pc,
    output logic               exe_fwd_valid,
    output logic               exe_fwd_data_valid
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ALU_OP_W = 19;
    localparam int unsigned CNT_W    = 6;

    // One-hot ALU operation bit positions
    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_SLT   = 2;
    localparam int unsigned OP_SLTU  = 3;
    localparam int unsigned OP_AND   = 4;
    localparam int unsigned OP_NOR   = 5;
    localparam int unsigned OP_OR    = 6;
    localparam int unsigned OP_XOR   = 7;
    localparam int unsigned OP_SLL   = 8;
    localparam int unsigned OP_SRL   = 9;
    localparam int unsigned OP_SRA   = 10;
    localparam int unsigned OP_LUI   = 11;
    localparam int unsigned OP_MUL   = 12;
    localparam int unsigned OP_MULH  = 13;
    localparam int unsigned OP_MULHU = 14;
    localparam int unsigned OP_ANDN  = 15;
    localparam int unsigned OP_ORN   = 16;
    localparam int unsigned OP_ROTR  = 17;
    localparam int unsigned OP_MOV   = 18;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    // Stage input register
    logic                exe_valid_q;
    logic [XLEN-1:0]     src1_q, src2_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic [2:0]          div_op_q;
    logic                rf_w_en_q, is_load_q;
    logic [4:0]          rf_w_addr_q;
    logic [SIDE_WD-1:0]  side_q;
    logic [XLEN-1:0]     pc_q;

    // Divider state
    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [XLEN-1:0]     rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, res_q, res_d;
    logic                neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

    logic                exe_ready_go;
    logic [XLEN-1:0]     alu_res;

    // Stage handshake
    assign exe_ready_go     = ~div_op_q[2] | (state_q == DONE);
    assign exe_allow_in     = ~exe_valid_q | (exe_ready_go & mem_allow_in);
    assign exe_to_mem_valid = exe_valid_q & exe_ready_go;

    // Latch the incoming instruction when the stage accepts it
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_valid_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            alu_op_q    <= '0;
            div_op_q    <= '0;
            rf_w_en_q   <= 1'b0;
            rf_w_addr_q <= '0;
            is_load_q   <= 1'b0;
            side_q      <= '0;
            pc_q        <= '0;
        end else begin
            if (exe_allow_in) exe_valid_q <= id_to_exe_valid;
            if (id_to_exe_valid && exe_allow_in) begin
                src1_q      <= id_src1;
                src2_q      <= id_src2;
                alu_op_q    <= id_alu_op;
                div_op_q    <= id_div_op;
                rf_w_en_q   <= id_rf_w_en;
                rf_w_addr_q <= id_rf_w_addr;
                is_load_q   <= id_is_load;
                side_q      <= id_side;
                pc_q        <= id_pc;
            end
        end
    end

    // One-hot ALU; mulhu is derived from the signed high product
    logic [4:0]      sh;
    logic [63:0]     prod_s;
    logic [XLEN-1:0] mulhu;
    assign sh     = src2_q[4:0];
    assign prod_s = 64'($signed({{32{src1_q[31]}}, src1_q}) * $signed({{32{src2_q[31]}}, src2_q}));
    assign mulhu  = prod_s[63:32] + (src1_q[31] ? src2_q : '0) + (src2_q[31] ? src1_q : '0);

    always_comb begin
        alu_res = '0;
        if (alu_op_q[OP_ADD])   alu_res = alu_res | (src1_q + src2_q);
        if (alu_op_q[OP_SUB])   alu_res = alu_res | (src1_q - src2_q);
        if (alu_op_q[OP_SLT])   alu_res = alu_res | {31'b0, $signed(src1_q) < $signed(src2_q)};
        if (alu_op_q[OP_SLTU])  alu_res = alu_res | {31'b0, src1_q < src2_q};
        if (alu_op_q[OP_AND])   alu_res = alu_res | (src1_q & src2_q);
        if (alu_op_q[OP_NOR])   alu_res = alu_res | ~(src1_q | src2_q);
        if (alu_op_q[OP_OR])    alu_res = alu_res | (src1_q | src2_q);
        if (alu_op_q[OP_XOR])   alu_res = alu_res | (src1_q ^ src2_q);
        if (alu_op_q[OP_SLL])   alu_res = alu_res | (src1_q << sh);
        if (alu_op_q[OP_SRL])   alu_res = alu_res | (src1_q >> sh);
        if (alu_op_q[OP_SRA])   alu_res = alu_res | 32'($signed(src1_q) >>> sh);
        if (alu_op_q[OP_LUI])   alu_res = alu_res | src2_q;
        if (alu_op_q[OP_MUL])   alu_res = alu_res | prod_s[31:0];
        if (alu_op_q[OP_MULH])  alu_res = alu_res | prod_s[63:32];
        if (alu_op_q[OP_MULHU]) alu_res = alu_res | mulhu;
        if (alu_op_q[OP_ANDN])  alu_res = alu_res | (src1_q & ~src2_q);
        if (alu_op_q[OP_ORN])   alu_res = alu_res | (src1_q | ~src2_q);
        if (alu_op_q[OP_ROTR])  alu_res = alu_res | ((src1_q >> sh) | (src1_q << (6'd32 - {1'b0, sh})));
        if (alu_op_q[OP_MOV])   alu_res = alu_res | src1_q;
    end

    // Divider operand magnitudes and one restoring iteration
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs, rem_nx, quo_nx, div_final;
    logic [XLEN:0]   shifted;
    logic            fits;
    assign a_neg   = div_op_q[0] & src1_q[31];
    assign b_neg   = div_op_q[0] & src2_q[31];
    assign a_abs   = a_neg ? (32'd0 - src1_q) : src1_q;
    assign b_abs   = b_neg ? (32'd0 - src2_q) : src2_q;
    assign shifted = {rem_q, quo_q[31]};
    assign fits    = shifted >= {1'b0, dvsr_q};
    assign rem_nx  = fits ? 32'(shifted - {1'b0, dvsr_q}) : shifted[31:0];
    assign quo_nx  = {quo_q[30:0], fits};
    assign div_final = div_op_q[1] ? (neg_rem_q ? (32'd0 - rem_nx) : rem_nx)
                     : (dz_q ? '1 : (neg_quo_q ? (32'd0 - quo_nx) : quo_nx));

    // Divider next-state logic
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        res_d     = res_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                if (exe_valid_q && div_op_q[2]) begin
                    dvsr_d    = b_abs;
                    quo_d     = a_abs;
                    rem_d     = '0;
                    count_d   = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = (src2_q == '0);
`ifdef EXE_DIV_EARLY_OUT_EN
                    if ((src2_q == '0) || (b_abs > a_abs)) begin
                        res_d   = div_op_q[1] ? src1_q : ((src2_q == '0) ? '1 : '0);
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                rem_d   = rem_nx;
                quo_d   = quo_nx;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(XLEN - 1)) begin
                    res_d   = div_final;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (mem_allow_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            res_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            res_q     <= res_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign exe_result         = div_op_q[2] ? res_q : alu_res;
    assign exe_rf_w_en        = rf_w_en_q;
    assign exe_rf_w_addr      = rf_w_addr_q;
    assign exe_side           = side_q;
    assign exe_pc             = pc_q;
    assign exe_fwd_valid      = exe_valid_q;
    assign exe_fwd_data_valid = exe_valid_q & rf_w_en_q & ~is_load_q & exe_ready_go;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed and randomized checks of exe_stage against an
// arithmetic reference model of the ALU and divide instructions.
module tb_exe_stage;

    localparam int unsigned SIDE_WD = 45;

    logic               clk = 1'b0;
    logic               reset;
    logic               id_to_exe_valid;
    logic               exe_allow_in;
    logic [31:0]        id_src1, id_src2;
    logic [18:0]        id_alu_op;
    logic [2:0]         id_div_op;
    logic               id_rf_w_en;
    logic [4:0]         id_rf_w_addr;
    logic               id_is_load;
    logic [SIDE_WD-1:0] id_side;
    logic [31:0]        id_pc;
    logic               mem_allow_in;
    logic               exe_to_mem_valid;
    logic [31:0]        exe_result;
    logic               exe_rf_w_en;
    logic [4:0]         exe_rf_w_addr;
    logic [SIDE_WD-1:0] exe_side;
    logic [31:0]        exe_pc;
    logic               exe_fwd_valid;
    logic               exe_fwd_data_valid;

    int n_cmp = 0;
    int n_mis = 0;

    exe_stage #(.SIDE_WD(SIDE_WD)) dut (
        .clk(clk), .reset(reset),
        .id_to_exe_valid(id_to_exe_valid), .exe_allow_in(exe_allow_in),
        .id_src1(id_src1), .id_src2(id_src2), .id_alu_op(id_alu_op),
        .id_div_op(id_div_op), .id_rf_w_en(id_rf_w_en), .id_rf_w_addr(id_rf_w_addr),
        .id_is_load(id_is_load), .id_side(id_side), .id_pc(id_pc),
        .mem_allow_in(mem_allow_in), .exe_to_mem_valid(exe_to_mem_valid),
        .exe_result(exe_result), .exe_rf_w_en(exe_rf_w_en), .exe_rf_w_addr(exe_rf_w_addr),
        .exe_side(exe_side), .exe_pc(exe_pc), .exe_fwd_valid(exe_fwd_valid),
        .exe_fwd_data_valid(exe_fwd_data_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: operation index -> plain arithmetic
    function automatic logic [31:0] alu_model(input int idx, input logic [31:0] a, input logic [31:0] b);
        longint      ps;
        logic [63:0] pu;
        logic [63:0] rot;
        ps  = longint'($signed(a)) * longint'($signed(b));
        pu  = {32'b0, a} * {32'b0, b};
        rot = {a, a} >> b[4:0];
        case (idx)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return $signed(a) >>> b[4:0];
            11: return b;
            12: return pu[31:0];
            13: return 32'(ps >>> 32);
            14: return pu[63:32];
            15: return a & ~b;
            16: return a | ~b;
            17: return rot[31:0];
            default: return a;
        endcase
    endfunction

    // Reference divide: truncating division with the architectural corner cases
    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic rem, input logic sgn);
        int sa, sb;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic longint mag(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) return -longint'($signed(v));
        return longint'({32'b0, v});
    endfunction

    function automatic int lat_model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
`ifdef EXE_DIV_EARLY_OUT_EN
        if (b == 32'd0 || mag(b, sgn) > mag(a, sgn)) return 1;
`endif
        return 33;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [18:0] aop,
                         input logic [2:0] dop, input logic wen, input logic ld, input logic [31:0] pc);
        id_src1      = a;
        id_src2      = b;
        id_alu_op    = aop;
        id_div_op    = dop;
        id_rf_w_en   = wen;
        id_rf_w_addr = 5'($urandom_range(1, 31));
        id_is_load   = ld;
        id_side      = SIDE_WD'({$urandom(), $urandom()});
        id_pc        = pc;
        id_to_exe_valid = 1'b1;
    endtask

    task automatic run_alu(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic wen, input logic ld);
        logic [31:0]        pc;
        logic [4:0]         wa;
        logic [SIDE_WD-1:0] sd;
        pc = $urandom();
        mem_allow_in = 1'b1;
        drive(a, b, 19'(1) << idx, 3'b000, wen, ld, pc);
        wa = id_rf_w_addr;
        sd = id_side;
        @(negedge clk);
        check("alu_accept", exe_allow_in, 1);
        @(posedge clk); #1;
        id_to_exe_valid = 1'b0;
        @(negedge clk);
        check("alu_to_mem_valid", exe_to_mem_valid, 1);
        check("alu_result", exe_result, alu_model(idx, a, b));
        check("alu_fwd_data_valid", exe_fwd_data_valid, wen & ~ld);
        check("alu_pc", exe_pc, pc);
        check("alu_side", exe_side, sd);
        check("alu_waddr", exe_rf_w_addr, wa);
        @(posedge clk); #1;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic rem,
                           input logic sgn, input int hold);
        logic [31:0] exp_res;
        logic [31:0] pc;
        logic [31:0] pc2;
        int          cyc;
        exp_res = div_model(a, b, rem, sgn);
        pc = $urandom();
        mem_allow_in = (hold == 0);
        drive(a, b, 19'd0, {1'b1, rem, sgn}, 1'b1, 1'b0, pc);
        @(negedge clk);
        check("div_accept", exe_allow_in, 1);
        @(posedge clk); #1;
        id_to_exe_valid = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (exe_to_mem_valid) break;
            if (cyc == 0) begin
                check("div_busy_allow_in", exe_allow_in, 0);
                check("div_busy_fwd_valid", exe_fwd_valid, 1);
                check("div_busy_fwd_data", exe_fwd_data_valid, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("div_latency", 64'(cyc), 64'(lat_model(a, b, sgn)));
        check("div_result", exe_result, exp_res);
        check("div_fwd_data_valid", exe_fwd_data_valid, 1);
        check("div_pc", exe_pc, pc);
        if (hold > 0) begin
            for (int k = 1; k < hold; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("hold_valid", exe_to_mem_valid, 1);
                check("hold_result", exe_result, exp_res);
                check("hold_allow_in", exe_allow_in, 0);
            end
            @(posedge clk); #1;
            mem_allow_in = 1'b1;
            pc2 = $urandom();
            drive(32'd100, 32'd23, 19'd1, 3'b000, 1'b1, 1'b0, pc2);
            @(negedge clk);
            check("release_allow_in", exe_allow_in, 1);
            check("release_result", exe_result, exp_res);
            @(posedge clk); #1;
            id_to_exe_valid = 1'b0;
            @(negedge clk);
            check("follow_valid", exe_to_mem_valid, 1);
            check("follow_result", exe_result, 32'd123);
            check("follow_pc", exe_pc, pc2);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        id_to_exe_valid = 1'b0;
        mem_allow_in = 1'b1;
        id_src1 = '0; id_src2 = '0; id_alu_op = '0; id_div_op = '0;
        id_rf_w_en = 1'b0; id_rf_w_addr = '0; id_is_load = 1'b0; id_side = '0; id_pc = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_fwd_valid", exe_fwd_valid, 0);
        check("rst_to_mem_valid", exe_to_mem_valid, 0);
        check("rst_allow_in", exe_allow_in, 1);
        check("rst_result", exe_result, 0);
        check("rst_fwd_data_valid", exe_fwd_data_valid, 0);
        @(posedge clk); #1;

        // Directed ALU add, then randomized ALU traffic
        run_alu(0, 32'd5, 32'd7, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++)
            run_alu($urandom_range(0, 18), $urandom(), $urandom(), 1'($urandom), 1'($urandom));

        // Directed divide corner cases
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0);
        run_div(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 0);
        run_div(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
        run_div(32'd3, 32'd10, 1'b0, 1'b0, 0);
        run_div(32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1, 0);
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 0);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 0);
        run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1'b1, 0);

        // Back-pressure on a finished divide, then hand off into a new instruction
        run_div(32'd1000, 32'd7, 1'b0, 1'b0, 5);

        // Reset in the middle of a divide
        mem_allow_in = 1'b1;
        drive(32'd100, 32'd7, 19'd0, 3'b100, 1'b1, 1'b0, 32'h1234);
        @(posedge clk); #1;
        id_to_exe_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_fwd_valid", exe_fwd_valid, 0);
        check("midrst_to_mem_valid", exe_to_mem_valid, 0);
        check("midrst_result", exe_result, 0);
        check("midrst_pc", exe_pc, 0);
        check("midrst_rf_w_en", exe_rf_w_en, 0);
        @(posedge clk); #1;
        run_div(32'd100, 32'd7, 1'b0, 1'b0, 0);

        // Randomized divides
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            run_div(a, b, 1'($urandom), 1'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
